// File: rtl/clock_tick_gen.sv
// clock_tick_gen: a bank of programmable divide-by-N tick channels plus a
// stretched active-low system reset. Each channel emits a one-cycle tick
// every D_eff cycles and a square wave that toggles on every tick. Channels
// stay idle until the stretched reset has been released.
module clock_tick_gen #(
  parameter  int CHANNELS = 4,
  parameter  int CNT_W    = 24,
  parameter  int RST_HOLD = 16,
  parameter  int DEF_DIV  = 1000000,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_wr_en,
  input  logic [CH_W-1:0]     i_wr_ch,
  input  logic [CNT_W-1:0]    i_wr_div,
  input  logic [CHANNELS-1:0] i_ch_en,
  output logic [CHANNELS-1:0] o_tick,
  output logic [CHANNELS-1:0] o_sq,
  output logic                o_nrst
);

  // Hold counter must be able to represent RST_HOLD itself (its saturation value).
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  DEF_DIV_T = CNT_W'(DEF_DIV);

  // ---------------------------------------------------------------------
  // Reset stretcher. After i_rst drops, the hold counter counts edges; on
  // the RST_HOLD-th edge o_nrst is registered high and stays there until
  // the next i_rst. o_nrst comes straight from a flop, so no input can
  // reach it combinationally.
  // ---------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [HOLD_W-1:0]   r_hold;
  logic [HOLD_W-1:0]   w_hold_next;
  logic                r_nrst;
  logic                w_nrst_next;

  // Stretcher state, hold counter and o_nrst flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_HOLD;
      r_hold  <= '0;
      r_nrst  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_hold  <= w_hold_next;
      r_nrst  <= w_nrst_next;
    end
  end

  // Next-state logic: count while holding, release on the last hold edge.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_nrst_next  = r_nrst;
    case (r_state)
      ST_HOLD: begin
        if (r_hold < HOLD_MAX) begin
          w_hold_next = r_hold + HOLD_W'(1);
        end
        if (r_hold == HOLD_LAST) begin
          w_state_next = ST_RUN;
          w_nrst_next  = 1'b1;
        end
      end
      ST_RUN: begin
        w_nrst_next = 1'b1;
      end
      default: begin
        w_state_next = ST_HOLD;
        w_nrst_next  = 1'b0;
      end
    endcase
  end

  assign o_nrst = r_nrst;

  // ---------------------------------------------------------------------
  // Tick channels. Each channel owns its divide value, counter, tick and
  // square-wave flops. A write to a channel always wins over counting in
  // the same cycle and restarts its count from zero without touching the
  // square-wave phase. Channels only count while the registered o_nrst is
  // high, so counting begins on the edge after o_nrst rises.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_lim;
    logic             r_tick;
    logic             r_sq;
    logic             w_wr_hit;
    logic             w_run;
    logic             w_wrap;

    // Out-of-range channel numbers never match any gi, so they are ignored.
    assign w_wr_hit = i_wr_en && (i_wr_ch == CH_W'(gi));
    assign w_run    = i_ch_en[gi] && r_nrst;
    // A stored divide of zero behaves as divide-by-one.
    assign w_lim    = (r_div == '0) ? '0 : (r_div - CNT_W'(1));
    assign w_wrap   = (r_cnt >= w_lim);

    // Per-channel divide register, counter, tick and square wave.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_div  <= DEF_DIV_T;
        r_cnt  <= '0;
        r_tick <= 1'b0;
        r_sq   <= 1'b0;
      end else if (w_wr_hit) begin
        r_div  <= i_wr_div;
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (w_run) begin
        if (w_wrap) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_sq   <= ~r_sq;
        end else begin
          r_cnt  <= r_cnt + CNT_W'(1);
          r_tick <= 1'b0;
        end
      end else begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end
    end

    assign o_tick[gi] = r_tick;
    assign o_sq[gi]   = r_sq;
  end

endmodule

// File: doc/clock_tick_gen.md
CLOCK_TICK_GEN -- requirements
Module: clock_tick_gen

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent tick channels (1..16).
REQ-002 Parameter CNT_W, default 24: width of divide value and per-channel counter.
REQ-003 Parameter RST_HOLD, default 16: cycles o_nrst stays low after i_rst deasserts (>=2).
REQ-004 Parameter DEF_DIV, default 1000000: divide value loaded into every channel at reset.
REQ-005 Derived CH_W = max(1, clog2(CHANNELS)).
REQ-006 i_clk  in  1: single clock; all state on rising edge.
REQ-007 i_rst  in  1: reset, asynchronous, active-high.
REQ-008 i_wr_en  in  1: divide-value write strobe.
REQ-009 i_wr_ch  in  CH_W: target channel of write.
REQ-010 i_wr_div  in  CNT_W: new divide value.
REQ-011 i_ch_en  in  CHANNELS: per-channel run enable.
REQ-012 o_tick  out  CHANNELS: registered one-cycle tick pulse per channel.
REQ-013 o_sq  out  CHANNELS: registered square wave, toggles on each tick.
REQ-014 o_nrst  out  1: registered active-low system reset, stretched release.

Function
REQ-015 Effective divide D_eff = 1 when stored div is 0, else stored div.
REQ-016 Channel runs when i_ch_en[n]=1 and o_nrst=1; per edge: if cnt >= D_eff-1 then cnt<=0, o_tick[n]<=1, o_sq[n]<=~o_sq[n]; else cnt<=cnt+1, o_tick[n]<=0.
REQ-017 From cnt=0, first tick is registered on the D_eff-th edge; thereafter period exactly D_eff cycles; o_sq period 2*D_eff.
REQ-018 D_eff=1: o_tick[n] held high continuously, o_sq[n] toggles every cycle.
REQ-019 Channel not running: cnt<=0, o_tick[n]<=0, o_sq[n] held.
REQ-020 Write: on edge with i_wr_en=1 and i_wr_ch<CHANNELS, div[i_wr_ch]<=i_wr_div, its cnt<=0, its o_tick<=0, its o_sq held.
REQ-021 Write takes priority over count/tick in the same cycle; first tick after write on D_eff-th edge after write edge (if running).
REQ-022 Write with i_wr_ch>=CHANNELS ignored, no state change.
REQ-023 Writes accepted regardless of i_ch_en and o_nrst; no other channel affected.
REQ-024 Reset stretcher: hold counter (width clog2(RST_HOLD+1)) counts up after i_rst release, saturates at RST_HOLD; o_nrst<=1 on the RST_HOLD-th rising edge after deassert, stays 1.
REQ-025 o_nrst has no combinational path from any input.

Reset
REQ-026 i_rst=1 immediately (async) forces: all cnt=0, o_tick=0, o_sq=0, o_nrst=0, hold counter=0, all div=DEF_DIV (truncated to CNT_W).
REQ-027 Reset asserted mid-operation aborts all counts and restarts the RST_HOLD sequence on release; no glitch tick on release.
REQ-028 While o_nrst=0 no channel ticks; counting starts the edge after o_nrst rises.

Verification (CHANNELS=3, CNT_W=8, RST_HOLD=4, DEF_DIV=10)
REQ-029 Pulse i_rst mid-run, release -> outputs 0 within same cycle; o_nrst=1 after 4th edge post-release; first ticks 10 edges after that.
REQ-030 All i_ch_en=1 after reset -> each o_tick high 1 cycle every 10; o_sq period 20, all channels in phase.
REQ-031 Write ch2 div=3 mid-count -> ch2 ticks 3rd edge after write then every 3; ch0/ch1 period 10 undisturbed; o_sq[2] not toggled by write.
REQ-032 Write ch1 div=0, then div=1 -> o_tick[1] constant 1, o_sq[1] toggles each cycle in both cases.
REQ-033 Drop i_ch_en[0] for 5 cycles at cnt=6, re-enable -> no tick while low, o_sq[0] held, next tick 10th edge after re-enable.
REQ-034 Write i_wr_ch=3 div=2 -> no channel change; simultaneous write ch0 on its tick edge -> write wins, no tick that cycle.
